gb_instr_issuer: RTL

- Hardware instruction source for gbprocessor: the transmit end of its clock/reset/valid/instruction/probe interface.
- Buffers 8-bit opcodes from a host in a small FIFO and issues each to the processor as a one-cycle valid pulse.
- Waits a fixed settle time after each issue, then samples the processor probe and returns {instruction, probe} as a one-cycle result.
- Replaces hand-written stimulus sequences with a reusable, back-pressured driver for benches and on-chip self-test.

---
 rtl/gb_instr_issuer_if.sv | 30 +++
 rtl/gb_instr_issuer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/gb_instr_issuer_if.sv
// Host/processor bundle for gb_instr_issuer: host push channel, issue
// channel to the processor, probe return and the per-opcode result strobe.
interface gb_instr_issuer_if #(
  parameter int PROBE_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_instruction;
  logic               valid;
  logic [7:0]         instruction;
  logic [PROBE_W-1:0] probe;
  logic               res_valid;
  logic [7:0]         res_instruction;
  logic [PROBE_W-1:0] res_probe;
  logic               idle;

  // Issuer side: accepts host words and probe, drives everything else.
  modport master (
    input  in_valid, in_instruction, probe,
    output in_ready, valid, instruction, res_valid, res_instruction,
           res_probe, idle
  );

  // Environment side: host plus processor model.
  modport slave (
    output in_valid, in_instruction, probe,
    input  in_ready, valid, instruction, res_valid, res_instruction,
           res_probe, idle
  );
endinterface

// File: rtl/gb_instr_issuer.sv
// Instruction source for gbprocessor: buffers host opcodes in a FIFO, issues
// each as a one-cycle valid pulse, waits SETTLE cycles, then returns the
// opcode together with the sampled processor probe.
module gb_instr_issuer #(
  parameter int DEPTH   = 8,
  parameter int SETTLE  = 4,
  parameter int PROBE_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  gb_instr_issuer_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT   = CW'(SETTLE - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // FSM and registered outputs
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [7:0]         instr_q, instr_d;
  logic               res_valid_q, res_valid_d;
  logic [7:0]         res_instr_q, res_instr_d;
  logic [PROBE_W-1:0] res_probe_q, res_probe_d;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  // Full refuses a push even when the FSM pops in the same cycle.
  assign push  = bus.in_valid && !full;

  // Opcode storage write port.
  // NOTE: the storage array has no reset; entries are only read when count
  // says they hold valid data, so flushing the pointers is sufficient.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.in_instruction;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the values from before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state and next-output logic for the issue/settle sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    instr_d     = instr_q;
    res_valid_d = 1'b0;
    res_instr_d = res_instr_q;
    res_probe_d = res_probe_q;
    pop         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          instr_d = mem[rd_ptr];
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          res_valid_d = 1'b1;
          res_instr_d = instr_q;
          res_probe_d = bus.probe;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight opcode.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      instr_q     <= 8'h00;
      res_valid_q <= 1'b0;
      res_instr_q <= 8'h00;
      res_probe_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      res_valid_q <= res_valid_d;
      res_instr_q <= res_instr_d;
      res_probe_q <= res_probe_d;
    end
  end

  assign bus.in_ready        = !full;
  assign bus.idle            = empty && (state_q == S_IDLE);
  assign bus.valid           = valid_q;
  assign bus.instruction     = instr_q;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_instruction = res_instr_q;
  assign bus.res_probe       = res_probe_q;

endmodule
